// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and defaults for the pipeline stage register with skid buffer.
// Bubbles carry an all-zero control field, so downstream write/mem enables stay inert.
package pipe_stage_skid_pkg;

  // Default EX/MEM payload: ctrl = {M[2:0], WB[1:0]}, data = branch_addr, alu_result, rd2, wr_addr.
  localparam int DEF_CTRL_W = 5;
  localparam int DEF_DATA_W = 101;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments while en is high, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         cnt <= '0;
    else if (en && (cnt != {W{1'b1}})) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// flush-to-bubble and a saturating stall-cycle counter.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int CTRL_W  = DEF_CTRL_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e            state, state_nxt;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              load_main_in, load_main_skid, load_skid;

  assign out_valid = (state != ST_EMPTY);
  assign out_ctrl  = {CTRL_W{out_valid}} & main_ctrl;
  assign out_data  = main_data;

  // With the skid buffer, ready depends only on registered state, which breaks the
  // combinational ready path back to the upstream stage.
  assign in_ready = (SKID_EN != 0) ? (state != ST_FULL) : (!out_valid || out_ready);

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_valid) begin
          state_nxt    = ST_ONE;
          load_main_in = 1'b1;
        end
        ST_ONE: begin
          if (out_ready) begin
            if (in_valid) load_main_in = 1'b1;
            else          state_nxt    = ST_EMPTY;
          end else if (in_valid && (SKID_EN != 0)) begin
            state_nxt = ST_FULL;
            load_skid = 1'b1;
          end
        end
        ST_FULL: if (out_ready) begin
          state_nxt      = ST_ONE;
          load_main_skid = 1'b1;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Flush only zeroes the control fields; data holds so out_data changes only on a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        main_ctrl <= '0;
        skid_ctrl <= '0;
      end else begin
        if (load_main_in) begin
          main_ctrl <= in_ctrl;
          main_data <= in_data;
        end else if (load_main_skid) begin
          main_ctrl <= skid_ctrl;
          main_data <= skid_data;
        end
        if (load_skid) begin
          skid_ctrl <= in_ctrl;
          skid_data <= in_data;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (out_valid && !out_ready),
    .cnt   (stall_cnt)
  );

endmodule
